// File: rtl/mod_74x161_chain_if.sv
// Control/data bundle for the cascaded 74x161/74x191 counter.
// master drives load, enables, direction and data; slave is the counter itself.
interface mod_74x161_chain_if #(
  parameter int SLICES = 2
);
  localparam int WIDTH = 4 * SLICES;

  logic              LOAD;
  logic              ENP;
  logic              ENT;
  logic              DN;
  logic [WIDTH-1:0]  D;
  logic [WIDTH-1:0]  Q;
  logic              RCO;
  logic              TC;
  logic [SLICES-1:0] SLICE_RCO;

  modport master (
    output LOAD, ENP, ENT, DN, D,
    input  Q, RCO, TC, SLICE_RCO
  );

  modport slave (
    input  LOAD, ENP, ENT, DN, D,
    output Q, RCO, TC, SLICE_RCO
  );
endinterface

// File: rtl/mod_74x161_chain.sv
// Synchronous binary counter built from cascaded 4-bit slices with carry lookahead,
// optional up/down direction and an optional programmable modulus.
module mod_74x161_chain #(
  parameter int              SLICES  = 2,
  parameter bit              UP_DOWN = 1'b0,
  parameter longint unsigned MODULUS = 0
) (
  input  logic               CLK,
  input  logic               RST,
  mod_74x161_chain_if.slave  bus
);
  localparam int WIDTH = 4 * SLICES;
  localparam logic [WIDTH-1:0] TOP =
    (MODULUS == 0) ? {WIDTH{1'b1}} : WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_chain;
  logic [WIDTH-1:0]  q_next;
  logic [SLICES-1:0] slice_term;
  logic [SLICES-1:0] slice_rco;
  logic              down;
  logic              count_en;
  logic              carry;

  assign down     = UP_DOWN & bus.DN;
  assign count_en = bus.ENP & bus.ENT;

  // Raw per-chip arithmetic: each slice steps only when every lower slice is terminal.
  always_comb begin
    // NOTE: every variable this block writes is given a default first, so no latch is inferred.
    slice_term = '0;
    slice_rco  = '0;
    q_chain    = q;
    carry      = bus.ENT;
    for (int i = 0; i < SLICES; i++) begin
      slice_term[i] = down ? (q[4*i +: 4] == 4'h0) : (q[4*i +: 4] == 4'hF);
      if (bus.ENP && carry)
        q_chain[4*i +: 4] = down ? (q[4*i +: 4] - 4'd1) : (q[4*i +: 4] + 4'd1);
      carry        = carry & slice_term[i];
      slice_rco[i] = carry;
    end
  end

  // Modulus wrap and out-of-range recovery override the nibble carries.
  always_comb begin
    q_next = q_chain;
    if (MODULUS != 0) begin
      if (down) begin
        if (q == '0 || q > TOP)
          q_next = TOP;
      end else if (q >= TOP) begin
        q_next = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)
      q <= '0;
    else if (bus.LOAD)
      q <= bus.D;
    else if (count_en)
      q <= q_next;
  end

  assign bus.Q         = q;
  assign bus.TC        = down ? (q == '0) : (q == TOP);
  assign bus.RCO       = bus.ENT & bus.TC;
  assign bus.SLICE_RCO = slice_rco;
endmodule
